sine_pwm_dac: RTL and testbench
===============================

// Module: sine_pwm_dac
// PURPOSE
//  Downstream consumer of the sinewave generator: turns its signed 16-bit samples
//  (sin_val, strobed by cnt_edge) into a single-bit PWM stream for an external RC filter.
//  Samples are double-buffered (pending -> active) and applied only at PWM period boundaries.
//  Arrival-rate problems are reported: overwritten samples pulse overrun and increment a counter.
// PARAMETERS
//  DATA_W    16  sample width, two's complement
//  PWM_BITS   8  PWM resolution; period = 2**PWM_BITS clk cycles (256 clocks at 10 MHz = 25.6 us)
// PORTS
//  clk          in   1         system clock (10 MHz)
//  reset        in   1         asynchronous, active-high reset
//  sin_val      in   DATA_W    signed sample from sinewave
//  sin_valid    in   1         1-cycle strobe, sin_val valid (driven by cnt_edge)
//  pwm_out      out  1         PWM output, registered
//  period_start out  1         1-cycle pulse, first clock of each PWM period
//  sample_taken out  1         1-cycle pulse, pending sample moved to active duty
//  overrun      out  1         1-cycle pulse, unconsumed pending sample overwritten
//  overrun_cnt  out  8         saturating count of overrun events
// BEHAVIOUR
//  Reset (async, immediate, also mid-period): pwm_cnt=0, pending_full=0, pending=0,
//   duty_active=2**(PWM_BITS-1) (mid-scale), pwm_out=0, period_start=0, sample_taken=0,
//   overrun=0, overrun_cnt=0.
//  Conversion: duty = top PWM_BITS bits of offset-binary {~sin_val[DATA_W-1], sin_val[DATA_W-2:0]}.
//   -32768 -> 0, 0 -> 128, +32767 -> 255 (for defaults). Done at capture time; width PWM_BITS.
//  pwm_cnt: free-running 0..2**PWM_BITS-1, +1 every clk, wraps to 0.
//  Capture: sin_valid=1 -> pending<=duty(sin_val), pending_full<=1.
//   If pending_full already 1 and no transfer in the same cycle -> overrun=1 next cycle,
//   overrun_cnt+1 (saturates at 255); the newest sample wins.
//  Transfer: in the cycle pwm_cnt==MAX, if pending_full: duty_active<=pending,
//   pending_full<=0, sample_taken=1 next cycle. If pending_full=0: duty_active holds.
//  Simultaneous transfer + sin_valid: old pending -> duty_active, new sample -> pending,
//   pending_full stays 1, no overrun.
//  Outputs (registered, 1-cycle latency from pwm_cnt):
//   pwm_out <= (pwm_cnt < duty_active); period_start <= (pwm_cnt==0).
//   New duty therefore governs the whole period starting at the next period_start.
//  Duty 0 -> pwm_out constantly 0; duty 255 -> high 255 of 256 cycles (never 100 %).
//  No FSM beyond pending_full flag; pending/active are the two-state sample buffer.
// TESTING
//  1 Reset release, no samples -> period_start every 256 clk; pwm_out high 128 clk per period.
//  2 One sample sin_val=16'h8000 mid-period -> sample_taken at period end; next period pwm_out=0 all 256 clk.
//  3 sin_val=16'h7FFF -> next period pwm_out high exactly 255 clk; 16'h0000 -> 128 clk; 16'h4000 -> 192 clk.
//  4 Two sin_valid in one period (0x4000 then 0xC000) -> 1 overrun pulse, overrun_cnt=1, next duty=64.
//  5 sin_valid exactly on pwm_cnt==255 with pending full -> no overrun; pending applied, new sample next period.
//  6 300 overruns -> overrun_cnt=255; assert reset mid-period -> all outputs reset values
//    same cycle, duty back to 128.

Source files
------------

// File: rtl/sine_pwm_dac.sv
// sine_pwm_dac
//   Turns signed samples from the sinewave generator into a single-bit PWM stream
//   for an external RC filter. Each incoming sample lands in a pending buffer.
//   At the last clock of every PWM period the pending sample, if any, moves into
//   the active duty register. The new duty then governs the whole following period.
//   A sample that overwrites an unconsumed pending sample is reported as an overrun.
//
// Ports
//   clk          in   1        system clock
//   reset        in   1        asynchronous, active-high reset
//   sin_val      in   DATA_W   signed two's-complement sample
//   sin_valid    in   1        one-cycle strobe qualifying sin_val
//   pwm_out      out  1        registered PWM output
//   period_start out  1        one-cycle pulse on the first clock of each PWM period
//   sample_taken out  1        one-cycle pulse after pending moved to active duty
//   overrun      out  1        one-cycle pulse after an unconsumed pending sample was overwritten
//   overrun_cnt  out  8        saturating count of overrun events

module sine_pwm_dac #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned PWM_BITS = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] sin_val,
    input  logic              sin_valid,
    output logic              pwm_out,
    output logic              period_start,
    output logic              sample_taken,
    output logic              overrun,
    output logic [7:0]        overrun_cnt
);

    localparam logic [PWM_BITS-1:0] CNT_MAX  = {PWM_BITS{1'b1}};
    localparam logic [PWM_BITS-1:0] DUTY_MID = {1'b1, {(PWM_BITS-1){1'b0}}};
    localparam logic [7:0]          OVR_MAX  = 8'hFF;

    // State
    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [PWM_BITS-1:0] pending_q, pending_d;
    logic                pending_full_q, pending_full_d;
    logic [PWM_BITS-1:0] duty_active_q, duty_active_d;
    logic                pwm_out_q, pwm_out_d;
    logic                period_start_q, period_start_d;
    logic                sample_taken_q, sample_taken_d;
    logic                overrun_q, overrun_d;
    logic [7:0]          overrun_cnt_q, overrun_cnt_d;

    // Combinational helpers
    logic [PWM_BITS-1:0] sample_duty;
    logic                period_end;
    logic                transfer;
    logic                overwrite;

    // Offset-binary conversion: flipping the sign bit maps the most negative sample
    // to 0 and the most positive to all-ones; keep only the top PWM_BITS bits.
    assign sample_duty = {~sin_val[DATA_W-1], sin_val[DATA_W-2 -: PWM_BITS-1]};

    assign period_end = (pwm_cnt_q == CNT_MAX);
    assign transfer   = period_end && pending_full_q;
    // A transfer in the same cycle consumes the old sample, so the new one is not an overrun.
    assign overwrite  = sin_valid && pending_full_q && !transfer;

    always_comb begin
        pwm_cnt_d      = pwm_cnt_q + 1'b1;
        pending_d      = pending_q;
        pending_full_d = pending_full_q;
        duty_active_d  = duty_active_q;
        overrun_cnt_d  = overrun_cnt_q;

        if (transfer) begin
            duty_active_d  = pending_q;
            pending_full_d = 1'b0;
        end

        // Capture takes priority over the transfer clearing the flag: the newest sample
        // always ends up pending.
        if (sin_valid) begin
            pending_d      = sample_duty;
            pending_full_d = 1'b1;
        end

        if (overwrite && (overrun_cnt_q != OVR_MAX)) begin
            overrun_cnt_d = overrun_cnt_q + 8'd1;
        end

        // Outputs lag the counter by one clock.
        pwm_out_d      = (pwm_cnt_q < duty_active_q);
        period_start_d = (pwm_cnt_q == '0);
        sample_taken_d = transfer;
        overrun_d      = overwrite;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pwm_cnt_q      <= '0;
            pending_q      <= '0;
            pending_full_q <= 1'b0;
            duty_active_q  <= DUTY_MID;
            pwm_out_q      <= 1'b0;
            period_start_q <= 1'b0;
            sample_taken_q <= 1'b0;
            overrun_q      <= 1'b0;
            overrun_cnt_q  <= '0;
        end else begin
            pwm_cnt_q      <= pwm_cnt_d;
            pending_q      <= pending_d;
            pending_full_q <= pending_full_d;
            duty_active_q  <= duty_active_d;
            pwm_out_q      <= pwm_out_d;
            period_start_q <= period_start_d;
            sample_taken_q <= sample_taken_d;
            overrun_q      <= overrun_d;
            overrun_cnt_q  <= overrun_cnt_d;
        end
    end

    assign pwm_out      = pwm_out_q;
    assign period_start = period_start_q;
    assign sample_taken = sample_taken_q;
    assign overrun      = overrun_q;
    assign overrun_cnt  = overrun_cnt_q;

endmodule

// File: tb/tb_sine_pwm_dac.sv
module tb_sine_pwm_dac;

    logic        clk;
    logic        reset;
    logic [15:0] sin_val;
    logic        sin_valid;
    logic        pwm_out;
    logic        period_start;
    logic        sample_taken;
    logic        overrun;
    logic [7:0]  overrun_cnt;

    int checks   = 0;
    int failures = 0;

    sine_pwm_dac #(
        .DATA_W   (16),
        .PWM_BITS (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .sin_val      (sin_val),
        .sin_valid    (sin_valid),
        .pwm_out      (pwm_out),
        .period_start (period_start),
        .sample_taken (sample_taken),
        .overrun      (overrun),
        .overrun_cnt  (overrun_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: time since reset in clocks, plus the two-slot sample buffer.
    int  m_t;          // clock edges since reset release
    int  m_pending;
    bit  m_full;
    int  m_active;
    int  m_ovr;
    int  e_pwm, e_ps, e_taken, e_ovr;
    int  per_duty;     // duty expected to govern the current period
    int  per_high;     // observed high clocks in the current period
    bit  per_valid;

    function automatic int to_duty(input logic [15:0] v);
        return (int'($signed(v)) + 32768) / 256;
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s t=%0d observed=%0d expected=%0d", tag, m_t, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_t       = 0;
        m_pending = 0;
        m_full    = 0;
        m_active  = 128;
        m_ovr     = 0;
        per_valid = 0;
        per_high  = 0;
        per_duty  = 128;
    endtask

    // One clock with the given inputs, then compare every output against the model.
    task automatic step(input bit v, input logic [15:0] sv);
        int  phase;
        bit  xfer;
        sin_valid = v;
        sin_val   = sv;
        @(posedge clk);
        phase   = m_t % 256;
        e_ps    = (phase == 0);
        e_pwm   = (phase < m_active);
        xfer    = (phase == 255) && m_full;
        e_taken = xfer;
        e_ovr   = v && m_full && !xfer;
        if (e_ovr && m_ovr < 255) m_ovr++;
        if (phase == 0) begin
            if (per_valid) check("period_high", per_high, per_duty);
            per_valid = 1;
            per_duty  = m_active;
            per_high  = 0;
        end
        if (xfer) begin
            m_active = m_pending;
            m_full   = 0;
        end
        if (v) begin
            m_pending = to_duty(sv);
            m_full    = 1;
        end
        m_t++;
        #1;
        per_high += int'(pwm_out);
        check("pwm_out", int'(pwm_out), e_pwm);
        check("period_start", int'(period_start), e_ps);
        check("sample_taken", int'(sample_taken), e_taken);
        check("overrun", int'(overrun), e_ovr);
        check("overrun_cnt", int'(overrun_cnt), m_ovr);
        sin_valid = 1'b0;
    endtask

    // Idle until the counter phase seen by the next edge equals target.
    task automatic idle_to(input int target);
        while ((m_t % 256) != target) step(1'b0, 16'h0000);
    endtask

    task automatic idle_n(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 16'h0000);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_pwm_out"}, int'(pwm_out), 0);
        check({tag, "_period_start"}, int'(period_start), 0);
        check({tag, "_sample_taken"}, int'(sample_taken), 0);
        check({tag, "_overrun"}, int'(overrun), 0);
        check({tag, "_overrun_cnt"}, int'(overrun_cnt), 0);
    endtask

    initial begin
        logic [15:0] r;
        reset     = 1'b1;
        sin_valid = 1'b0;
        sin_val   = 16'h0000;
        model_reset();
        #23;
        check_reset_values("reset");
        @(negedge clk);
        reset = 1'b0;

        // Idle periods at mid-scale duty.
        idle_n(600);

        // Most negative sample mid-period -> duty 0 next period.
        idle_to(100);
        step(1'b1, 16'h8000);
        idle_to(0);
        idle_n(300);

        // Full scale, zero and quarter scale.
        idle_to(40);
        step(1'b1, 16'h7FFF);
        idle_to(0);
        idle_n(300);
        step(1'b1, 16'h0000);
        idle_to(0);
        idle_n(300);
        step(1'b1, 16'h4000);
        idle_to(0);
        idle_n(300);

        // Two samples in one period: one overrun, newest (duty 64) wins.
        idle_to(30);
        step(1'b1, 16'h4000);
        idle_n(20);
        step(1'b1, 16'hC000);
        idle_to(0);
        idle_n(300);

        // Sample on the transfer cycle with pending full: no overrun.
        idle_to(50);
        step(1'b1, 16'h2000);
        idle_to(255);
        step(1'b1, 16'hE000);
        idle_to(0);
        idle_n(300);
        check("overrun_cnt_after_edge_case", int'(overrun_cnt), 1);

        // Randomized sparse samples.
        for (int i = 0; i < 3000; i++) begin
            r = 16'($urandom);
            step(($urandom_range(0, 149) == 0), r);
        end

        // Flood to saturate the overrun counter.
        for (int i = 0; i < 400; i++) begin
            r = 16'($urandom);
            step(1'b1, r);
        end
        check("overrun_cnt_saturated", int'(overrun_cnt), 255);

        // Asynchronous reset mid-period.
        idle_to(77);
        #2;
        reset = 1'b1;
        #1;
        check_reset_values("midreset");
        @(posedge clk);
        #1;
        check_reset_values("midreset_held");
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        idle_n(600);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog t=%0d observed=timeout expected=finish", m_t);
        $fatal(1, "watchdog expired");
    end

endmodule
